// File: rtl/bp_zynq_host_io_responder_pkg.sv
// Shared definitions for the Zynq host I/O responder: host-region offsets and FSM states.
package bp_zynq_host_io_responder_pkg;

  typedef enum logic [0:0] {
    e_ready,
    e_resp
  } host_state_e;

  localparam logic [31:0] host_mbox_data_offset_gp   = 32'h0_1000;
  localparam logic [31:0] host_mbox_status_offset_gp = 32'h0_1008;
  localparam logic [31:0] host_finish_offset_gp      = 32'h0_2000;

endpackage

// File: rtl/bp_zynq_host_io_responder_fifo.sv
// Small 1-read/1-write FIFO (power-of-two depth) carrying BP writes to the PS.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rd_ptr_r, wr_ptr_r;
  logic [ptr_w:0]     count_r;
  logic               full, push;

  assign full    = (count_r == (ptr_w+1)'(els_p));
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign ready_o = ~full | yumi_i;
  assign v_o     = (count_r != '0);
  assign push    = v_i & ready_o;
  assign data_o  = mem[rd_ptr_r];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push)   wr_ptr_r <= wr_ptr_r + 1'b1;
      if (yumi_i) rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_r + (ptr_w+1)'(push) - (ptr_w+1)'(yumi_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_zynq_host_io_responder.sv
// Answers BP uncached I/O to the host region: queues writes for the PS, serves mailbox reads.
// Optional BP_ZYNQ_HOST_FINISH_EN: write to the finish offset raises sticky finish/fail flags.
module bp_zynq_host_io_responder
  import bp_zynq_host_io_responder_pkg::*;
#(
  parameter int unsigned paddr_width_p       = 33,
  parameter int unsigned host_offset_width_p = 20,
  parameter int unsigned fifo_els_p          = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           fwd_v_i,
  output logic                           fwd_ready_and_o,
  input  logic                           fwd_wr_i,
  input  logic [paddr_width_p-1:0]       fwd_addr_i,
  input  logic [1:0]                     fwd_size_i,
  input  logic [63:0]                    fwd_data_i,
  output logic                           rev_v_o,
  input  logic                           rev_ready_and_i,
  output logic                           rev_wr_o,
  output logic [paddr_width_p-1:0]       rev_addr_o,
  output logic [1:0]                     rev_size_o,
  output logic [63:0]                    rev_data_o,
  output logic                           host_v_o,
  input  logic                           host_yumi_i,
  output logic [host_offset_width_p-1:0] host_addr_o,
  output logic [1:0]                     host_size_o,
  output logic [63:0]                    host_data_o,
  input  logic                           mbox_w_i,
  input  logic [63:0]                    mbox_data_i,
  output logic                           finish_o,
  output logic                           fail_o
);

  localparam int unsigned entry_w = host_offset_width_p + 66;

  host_state_e state_r, state_n;
  logic        fwd_ready, fwd_accept, fifo_ready;
  logic [31:0] fwd_offset;
  logic [63:0] rd_data;
  logic [63:0] mbox_data_r;
  logic        mbox_v_r;
  logic [entry_w-1:0] fifo_data;

  assign fwd_offset      = 32'(fwd_addr_i[host_offset_width_p-1:0]);
  assign fwd_ready_and_o = fwd_ready;
  assign fwd_accept      = fwd_v_i & fwd_ready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n   = state_r;
    fwd_ready = 1'b0;
    rev_v_o   = 1'b0;
    case (state_r)
      e_ready: begin
        fwd_ready = ~reset_i & (~fwd_wr_i | fifo_ready);
        if (fwd_v_i && fwd_ready) state_n = e_resp;
      end
      e_resp: begin
        rev_v_o = 1'b1;
        if (rev_ready_and_i) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (!fwd_wr_i) begin
      if (fwd_offset == host_mbox_data_offset_gp)        rd_data = mbox_data_r;
      else if (fwd_offset == host_mbox_status_offset_gp) rd_data = {63'b0, mbox_v_r};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rev_wr_o    <= 1'b0;
      rev_addr_o  <= '0;
      rev_size_o  <= '0;
      rev_data_o  <= '0;
      mbox_data_r <= '0;
      mbox_v_r    <= 1'b0;
    end else begin
      if (fwd_accept) begin
        rev_wr_o   <= fwd_wr_i;
        rev_addr_o <= fwd_addr_i;
        rev_size_o <= fwd_size_i;
        rev_data_o <= rd_data;
      end
      // A PS mailbox write beats a simultaneous BP read-and-clear.
      if (mbox_w_i) begin
        mbox_data_r <= mbox_data_i;
        mbox_v_r    <= 1'b1;
      end else if (fwd_accept && !fwd_wr_i && fwd_offset == host_mbox_data_offset_gp) begin
        mbox_v_r <= 1'b0;
      end
    end
  end

`ifdef BP_ZYNQ_HOST_FINISH_EN
  logic finish_r, fail_r;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      finish_r <= 1'b0;
      fail_r   <= 1'b0;
    end else if (fwd_accept && fwd_wr_i && fwd_offset == host_finish_offset_gp) begin
      finish_r <= 1'b1;
      fail_r   <= fail_r | fwd_data_i[0];
    end
  end
  assign finish_o = finish_r;
  assign fail_o   = fail_r;
`else
  assign finish_o = 1'b0;
  assign fail_o   = 1'b0;
`endif

  bsg_fifo_1r1w_small #(
    .width_p (entry_w),
    .els_p   (fifo_els_p)
  ) write_queue (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (fwd_accept & fwd_wr_i),
    .ready_o (fifo_ready),
    .data_i  ({fwd_addr_i[host_offset_width_p-1:0], fwd_size_i, fwd_data_i}),
    .v_o     (host_v_o),
    .data_o  (fifo_data),
    .yumi_i  (host_yumi_i)
  );

  assign host_addr_o = fifo_data[entry_w-1 -: host_offset_width_p];
  assign host_size_o = fifo_data[65:64];
  assign host_data_o = fifo_data[63:0];

endmodule

// File: tb/tb_bp_zynq_host_io_responder.sv
// Bench for bp_zynq_host_io_responder: table vectors, corner sequences, random traffic vs a model.
module tb_bp_zynq_host_io_responder;

`ifdef BP_ZYNQ_HOST_FINISH_EN
  localparam bit fin_en = 1'b1;
`else
  localparam bit fin_en = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        fwd_v_i = 1'b0, fwd_ready_and_o, fwd_wr_i = 1'b0;
  logic [32:0] fwd_addr_i = '0;
  logic [1:0]  fwd_size_i = '0;
  logic [63:0] fwd_data_i = '0;
  logic        rev_v_o, rev_ready_and_i = 1'b0, rev_wr_o;
  logic [32:0] rev_addr_o;
  logic [1:0]  rev_size_o;
  logic [63:0] rev_data_o;
  logic        host_v_o, host_yumi_i = 1'b0;
  logic [19:0] host_addr_o;
  logic [1:0]  host_size_o;
  logic [63:0] host_data_o;
  logic        mbox_w_i = 1'b0;
  logic [63:0] mbox_data_i = '0;
  logic        finish_o, fail_o;

  bp_zynq_host_io_responder #(
    .paddr_width_p       (33),
    .host_offset_width_p (20),
    .fifo_els_p          (4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fwd_v_i(fwd_v_i), .fwd_ready_and_o(fwd_ready_and_o), .fwd_wr_i(fwd_wr_i),
    .fwd_addr_i(fwd_addr_i), .fwd_size_i(fwd_size_i), .fwd_data_i(fwd_data_i),
    .rev_v_o(rev_v_o), .rev_ready_and_i(rev_ready_and_i), .rev_wr_o(rev_wr_o),
    .rev_addr_o(rev_addr_o), .rev_size_o(rev_size_o), .rev_data_o(rev_data_o),
    .host_v_o(host_v_o), .host_yumi_i(host_yumi_i), .host_addr_o(host_addr_o),
    .host_size_o(host_size_o), .host_data_o(host_data_o),
    .mbox_w_i(mbox_w_i), .mbox_data_i(mbox_data_i),
    .finish_o(finish_o), .fail_o(fail_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [19:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } hent_t;

  typedef struct {
    bit          wr;
    logic [32:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  int unsigned vectors = 0, miscompares = 0;

  // Reference model state
  hent_t       mq[$];
  logic [63:0] m_data = '0;
  bit          m_valid = 1'b0, m_fin = 1'b0, m_fail = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] model_access(bit wr, logic [32:0] addr, logic [1:0] size,
                                               logic [63:0] data);
    logic [19:0] off;
    off = addr[19:0];
    if (wr) begin
      mq.push_back({off, size, data});
      if (fin_en && off == 20'h02000) begin
        m_fin = 1'b1;
        m_fail = m_fail | data[0];
      end
      return 64'd0;
    end
    if (off == 20'h01000) begin
      m_valid = 1'b0;
      return m_data;
    end
    if (off == 20'h01008) return {63'd0, m_valid};
    return 64'd0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_data = '0; m_valid = 1'b0; m_fin = 1'b0; m_fail = 1'b0;
  endfunction

  task automatic send(input bit wr, input logic [32:0] addr, input logic [1:0] size,
                      input logic [63:0] data, input bit use_exp, input logic [63:0] exp);
    logic [63:0] mdl;
    int unsigned waited;
    @(negedge clk_i);
    fwd_v_i = 1'b1; fwd_wr_i = wr; fwd_addr_i = addr; fwd_size_i = size; fwd_data_i = data;
    waited = 0;
    #1;
    while (!fwd_ready_and_o && waited < 20) begin
      @(negedge clk_i); #1; waited++;
    end
    if (!fwd_ready_and_o) begin
      chk("fwd_accept_timeout", {63'd0, fwd_ready_and_o}, 64'd1);
      fwd_v_i = 1'b0;
      return;
    end
    mdl = model_access(wr, addr, size, data);
    @(posedge clk_i);
    #1 fwd_v_i = 1'b0;
    chk("rev_v_next_cycle", {63'd0, rev_v_o}, 64'd1);
    chk("rev_wr", {63'd0, rev_wr_o}, {63'd0, wr});
    chk("rev_addr", {31'd0, rev_addr_o}, {31'd0, addr});
    chk("rev_size", {62'd0, rev_size_o}, {62'd0, size});
    chk("rev_data_model", rev_data_o, mdl);
    if (use_exp) chk("rev_data_table", rev_data_o, exp);
    chk("fwd_ready_in_resp", {63'd0, fwd_ready_and_o}, 64'd0);
    if (wr) chk("host_v_after_write", {63'd0, host_v_o}, 64'd1);
    rev_ready_and_i = 1'b1;
    @(posedge clk_i);
    #1 rev_ready_and_i = 1'b0;
    chk("finish", {63'd0, finish_o}, {63'd0, m_fin});
    chk("fail", {63'd0, fail_o}, {63'd0, m_fail});
  endtask

  task automatic pop();
    hent_t h;
    @(negedge clk_i); #1;
    if (mq.size() == 0) begin
      chk("pop_empty_model", {63'd0, host_v_o}, 64'd0);
      return;
    end
    h = mq.pop_front();
    chk("host_v", {63'd0, host_v_o}, 64'd1);
    chk("host_addr", {44'd0, host_addr_o}, {44'd0, h.addr});
    chk("host_size", {62'd0, host_size_o}, {62'd0, h.size});
    chk("host_data", host_data_o, h.data);
    host_yumi_i = 1'b1;
    @(posedge clk_i);
    #1 host_yumi_i = 1'b0;
  endtask

  task automatic mbox_write(input logic [63:0] d);
    @(negedge clk_i);
    mbox_w_i = 1'b1; mbox_data_i = d;
    @(posedge clk_i);
    #1 mbox_w_i = 1'b0;
    m_data = d; m_valid = 1'b1;
  endtask

  vec_t tbl [8];
  logic [63:0] mdl;
  logic [32:0] a;
  logic [19:0] offs [4];

  initial begin
    tbl[0] = '{1'b1, 33'h0_0000_0000, 2'd0, 64'h41, 64'h0};
    tbl[1] = '{1'b0, 33'h0_0000_1008, 2'd3, 64'h0, 64'h1};
    tbl[2] = '{1'b0, 33'h0_0000_1000, 2'd3, 64'h0, 64'hDEAD};
    tbl[3] = '{1'b0, 33'h0_0000_1008, 2'd3, 64'h0, 64'h0};
    tbl[4] = '{1'b0, 33'h1_0000_1000, 2'd3, 64'h0, 64'hDEAD};
    tbl[5] = '{1'b0, 33'h0_0000_0100, 2'd2, 64'h0, 64'h0};
    tbl[6] = '{1'b1, 33'h0_0001_0008, 2'd3, 64'h0123456789ABCDEF, 64'h0};
    tbl[7] = '{1'b0, 33'h0_0ABC_D008, 2'd3, 64'h0, 64'h0};
    offs[0] = 20'h01000; offs[1] = 20'h01008; offs[2] = 20'h02000; offs[3] = 20'h00000;

    // Reset values
    #2;
    chk("reset_fwd_ready", {63'd0, fwd_ready_and_o}, 64'd0);
    chk("reset_rev_v", {63'd0, rev_v_o}, 64'd0);
    chk("reset_host_v", {63'd0, host_v_o}, 64'd0);
    chk("reset_finish", {63'd0, finish_o}, 64'd0);
    chk("reset_fail", {63'd0, fail_o}, 64'd0);
    @(negedge clk_i); reset_i = 1'b0;
    #1 chk("idle_fwd_ready", {63'd0, fwd_ready_and_o}, 64'd1);

    // Table vectors
    mbox_write(64'hDEAD);
    for (int i = 0; i < 8; i++)
      send(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].data, 1'b1, tbl[i].exp);
    pop();
    pop();

    // Mailbox write racing a BP read of the data word: old data returned, valid stays set
    mbox_write(64'h1111);
    @(negedge clk_i);
    fwd_v_i = 1'b1; fwd_wr_i = 1'b0; fwd_addr_i = 33'h1000; fwd_size_i = 2'd3;
    mbox_w_i = 1'b1; mbox_data_i = 64'hBEEF;
    #1 chk("race_ready", {63'd0, fwd_ready_and_o}, 64'd1);
    @(posedge clk_i);
    #1 fwd_v_i = 1'b0; mbox_w_i = 1'b0;
    chk("race_old_data", rev_data_o, 64'h1111);
    rev_ready_and_i = 1'b1;
    @(posedge clk_i);
    #1 rev_ready_and_i = 1'b0;
    m_data = 64'hBEEF; m_valid = 1'b1;
    send(1'b0, 33'h1008, 2'd3, '0, 1'b1, 64'h1);
    send(1'b0, 33'h1000, 2'd3, '0, 1'b1, 64'hBEEF);

    // Fill the queue; fifth write stalls, a read slips past, one yumi admits it
    for (int i = 0; i < 4; i++) send(1'b1, 33'(i * 8), 2'd3, 64'(100 + i), 1'b0, '0);
    @(negedge clk_i);
    fwd_v_i = 1'b1; fwd_wr_i = 1'b1; fwd_addr_i = 33'h50; fwd_size_i = 2'd1; fwd_data_i = 64'h5555;
    #1 chk("full_stall_a", {63'd0, fwd_ready_and_o}, 64'd0);
    @(negedge clk_i);
    #1 chk("full_stall_b", {63'd0, fwd_ready_and_o}, 64'd0);
    fwd_v_i = 1'b0;
    send(1'b0, 33'h10, 2'd3, '0, 1'b1, 64'h0);
    @(negedge clk_i);
    fwd_v_i = 1'b1; fwd_wr_i = 1'b1; fwd_addr_i = 33'h50; fwd_size_i = 2'd1; fwd_data_i = 64'h5555;
    host_yumi_i = 1'b1;
    #1 chk("full_yumi_admits", {63'd0, fwd_ready_and_o}, 64'd1);
    chk("full_head_data", host_data_o, mq[0].data);
    @(posedge clk_i);
    #1 fwd_v_i = 1'b0; host_yumi_i = 1'b0;
    void'(mq.pop_front());
    mdl = model_access(1'b1, 33'h50, 2'd1, 64'h5555);
    chk("full_rev_v", {63'd0, rev_v_o}, 64'd1);
    rev_ready_and_i = 1'b1;
    @(posedge clk_i);
    #1 rev_ready_and_i = 1'b0;
    for (int i = 0; i < 4; i++) pop();
    #1 chk("drained", {63'd0, host_v_o}, 64'd0);

    // Backpressure on the response: fields held, no new request accepted
    @(negedge clk_i);
    fwd_v_i = 1'b1; fwd_wr_i = 1'b0; fwd_addr_i = 33'h1008; fwd_size_i = 2'd2;
    mdl = model_access(1'b0, 33'h1008, 2'd2, '0);
    @(posedge clk_i);
    #1 fwd_addr_i = 33'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      chk("hold_rev_v", {63'd0, rev_v_o}, 64'd1);
      chk("hold_rev_addr", {31'd0, rev_addr_o}, 64'h1008);
      chk("hold_rev_data", rev_data_o, mdl);
      chk("hold_no_accept", {63'd0, fwd_ready_and_o}, 64'd0);
    end
    fwd_v_i = 1'b0; rev_ready_and_i = 1'b1;
    @(posedge clk_i);
    #1 rev_ready_and_i = 1'b0;

    // Finish offset write (flags only move when the feature is built in)
    send(1'b1, 33'h2000, 2'd3, 64'h1, 1'b1, 64'h0);
    repeat (3) @(posedge clk_i);
    #1 chk("finish_sticky", {63'd0, finish_o}, {63'd0, fin_en});
    chk("fail_sticky", {63'd0, fail_o}, {63'd0, fin_en});
    pop();

    // Reset while a response is pending
    send(1'b1, 33'h30, 2'd3, 64'h77, 1'b0, '0);
    @(negedge clk_i);
    fwd_v_i = 1'b1; fwd_wr_i = 1'b0; fwd_addr_i = 33'h100; fwd_size_i = 2'd3;
    @(posedge clk_i);
    #1 fwd_v_i = 1'b0;
    chk("pre_reset_rev_v", {63'd0, rev_v_o}, 64'd1);
    reset_i = 1'b1;
    #1;
    chk("midreset_rev_v", {63'd0, rev_v_o}, 64'd0);
    chk("midreset_host_v", {63'd0, host_v_o}, 64'd0);
    chk("midreset_fwd_ready", {63'd0, fwd_ready_and_o}, 64'd0);
    model_reset();
    @(negedge clk_i); reset_i = 1'b0;
    #1 chk("post_reset_ready", {63'd0, fwd_ready_and_o}, 64'd1);
    chk("post_reset_finish", {63'd0, finish_o}, 64'd0);
    send(1'b0, 33'h1008, 2'd3, '0, 1'b1, 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      a = {13'($urandom), 20'h0};
      if ($urandom_range(0, 1) == 1) a[19:0] = offs[$urandom_range(0, 3)];
      else a[19:0] = 20'($urandom) & 20'hFFFF8;
      if (op < 4) begin
        if (mq.size() == 4) pop();
        send(1'b1, a, 2'($urandom), {$urandom, $urandom}, 1'b0, '0);
      end else if (op < 7) begin
        send(1'b0, a, 2'($urandom), '0, 1'b0, '0);
      end else if (op < 8) begin
        mbox_write({$urandom, $urandom});
      end else begin
        pop();
      end
    end
    while (mq.size() != 0) pop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
